bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Two-master arbiter for the serial system bus. Grants one master at a time with round-robin fairness.
//  Muxes the granted master's serial address/data/control lines onto the shared bus.
//  Decodes the master's slave select into a one-hot valid to one of three slave_in_port instances.
//  Returns the selected slave's ready/rx_done to the granted master only. A watchdog revokes a grant held too long.
// PARAMETERS
//  TIMEOUT_CYC  default 1024  max cycles a grant may be held before forced revoke (counter width = $clog2(TIMEOUT_CYC)+1)
// PORTS
//  clk            in   1   system clock, all state on posedge
//  reset          in   1   asynchronous, active-low reset
//  m1_req/m2_req  in   1   master bus request, held high for whole transaction (incl. burst)
//  m1_grant/m2_grant out 1 registered grant to master
//  mX_valid       in   1   master_valid from master X
//  mX_addr/mX_data/mX_burst in 1 serial address/data/burst bit from master X
//  mX_rd/mX_wr    in   1   read_en / write_en from master X
//  mX_sel         in   2   target slave id (0..2) from master X; held constant while granted
//  bus_addr/bus_data/bus_burst/bus_rd/bus_wr out 1 shared serial lines to all slaves
//  slave_valid    out  3   one-hot master_valid to slaves
//  slave_ready    in   3   slave_ready from each slave
//  slave_done     in   3   rx_done from each slave
//  mX_ready/mX_done out 1  selected slave's ready/done, routed to granted master only
//  timeout        out  1   one-cycle pulse when grant revoked by watchdog
//  sel_err        out  1   high while granted master drives mX_sel==3
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE, both grants 0, priority -> M1, counter 0, timeout 0.
//   All muxed outputs 0 (combinational from grant regs).
//  FSM: IDLE, GNT1, GNT2, TURN.
//   IDLE: sample reqs. Only m1_req -> GNT1. Only m2_req -> GNT2. Both -> master holding priority.
//    None -> stay. Grant reg asserts the cycle after req seen (1-cycle latency).
//   GNTx: counter increments every cycle. mX_req==0 -> TURN, grant drops next edge.
//    Counter reaches TIMEOUT_CYC-1 with req still high -> TURN, grant drops, timeout pulses 1 cycle.
//   TURN: one dead cycle, no grant. Clears counter. Priority set to the other master. -> IDLE.
//   Min gap between two grants = 2 cycles (TURN + IDLE sample).
//  Priority: flips only after a grant completes (normal or timeout). A lone requester is granted regardless.
//  Mux: when mX_grant=1, bus_* = mX_* and slave_valid[mX_sel] = mX_valid.
//   mX_ready = slave_ready[mX_sel]; mX_done = slave_done[mX_sel].
//   Non-granted master sees ready/done=0. No grant -> all bus_* and slave_valid 0.
//  mX_sel==3 while granted: slave_valid=0, ready/done=0, sel_err=1; grant otherwise unaffected.
//  Req dropped in same cycle it is first sampled: no grant issued.
//  Req re-raised during TURN is ignored until IDLE.
//  Reset asserted mid-transaction: grant and slave_valid drop immediately.
//   Slaves recover via their own idle/handshake logic.
//  Grant never changes while req held, except on timeout.
// TESTING
//  1 m1_req only, sel=1: m1_grant high 1 cycle later; slave_valid=3'b010 while m1_valid; release -> grant low next cycle.
//  2 m1_req & m2_req same cycle after reset: M1 granted; on release TURN 1 cycle, then M2 granted.
//  3 both held continuously: grants alternate M1,M2,M1 with exactly 1 TURN cycle plus 1 IDLE cycle between grants.
//  4 TIMEOUT_CYC=16, m2 holds req 40 cycles: grant revoked after 16 granted cycles; timeout pulses once; M1 then wins tie.
//  5 m1 granted with sel=3: sel_err=1, slave_valid=0, m1_ready=0; sel->0 gives slave_valid=3'b001.
//  6 reset low mid-burst: grants, slave_valid and bus_* are 0 within same cycle; after release, state IDLE, M1 priority.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with grant watchdog, serial bus mux
// and slave-select decode onto three slave ports.
`default_nettype none

module bus_arbiter #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       m1_req,
   input  logic       m2_req,
   output logic       m1_grant,
   output logic       m2_grant,
   input  logic       m1_valid,
   input  logic       m1_addr,
   input  logic       m1_data,
   input  logic       m1_burst,
   input  logic       m1_rd,
   input  logic       m1_wr,
   input  logic [1:0] m1_sel,
   input  logic       m2_valid,
   input  logic       m2_addr,
   input  logic       m2_data,
   input  logic       m2_burst,
   input  logic       m2_rd,
   input  logic       m2_wr,
   input  logic [1:0] m2_sel,
   output logic       bus_addr,
   output logic       bus_data,
   output logic       bus_burst,
   output logic       bus_rd,
   output logic       bus_wr,
   output logic [2:0] slave_valid,
   input  logic [2:0] slave_ready,
   input  logic [2:0] slave_done,
   output logic       m1_ready,
   output logic       m1_done,
   output logic       m2_ready,
   output logic       m2_done,
   output logic       timeout,
   output logic       sel_err
);

   localparam int            CW      = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, GNT1, GNT2, TURN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          prio, prio_nxt;      // 0: M1 wins a tie, 1: M2 wins a tie
   logic          timeout_nxt;

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      prio_nxt    = prio;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (m1_req && m2_req) state_nxt = prio ? GNT2 : GNT1;
            else if (m1_req)      state_nxt = GNT1;
            else if (m2_req)      state_nxt = GNT2;
         end
         GNT1: begin
            if (!m1_req) begin
               state_nxt = TURN;
               prio_nxt  = 1'b1;
            end else if (cnt == CNT_MAX) begin
               state_nxt   = TURN;
               prio_nxt    = 1'b1;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GNT2: begin
            if (!m2_req) begin
               state_nxt = TURN;
               prio_nxt  = 1'b0;
            end else if (cnt == CNT_MAX) begin
               state_nxt   = TURN;
               prio_nxt    = 1'b0;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         prio     <= 1'b0;
         timeout  <= 1'b0;
         m1_grant <= 1'b0;
         m2_grant <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         prio     <= prio_nxt;
         timeout  <= timeout_nxt;
         m1_grant <= (state_nxt == GNT1);
         m2_grant <= (state_nxt == GNT2);
      end
   end

   // Routing is driven purely from the grant flops so a reset clears it at once.
   logic       active, valid_sel, rdy_sel, done_sel;
   logic [1:0] sel;

   always_comb begin
      active      = m1_grant | m2_grant;
      sel         = m1_grant ? m1_sel : m2_sel;
      valid_sel   = m1_grant ? m1_valid : m2_valid;
      bus_addr    = 1'b0;
      bus_data    = 1'b0;
      bus_burst   = 1'b0;
      bus_rd      = 1'b0;
      bus_wr      = 1'b0;
      slave_valid = 3'b000;
      rdy_sel     = 1'b0;
      done_sel    = 1'b0;
      sel_err     = 1'b0;
      if (active) begin
         bus_addr  = m1_grant ? m1_addr  : m2_addr;
         bus_data  = m1_grant ? m1_data  : m2_data;
         bus_burst = m1_grant ? m1_burst : m2_burst;
         bus_rd    = m1_grant ? m1_rd    : m2_rd;
         bus_wr    = m1_grant ? m1_wr    : m2_wr;
         case (sel)
            2'd0: begin
               slave_valid = {2'b00, valid_sel};
               rdy_sel     = slave_ready[0];
               done_sel    = slave_done[0];
            end
            2'd1: begin
               slave_valid = {1'b0, valid_sel, 1'b0};
               rdy_sel     = slave_ready[1];
               done_sel    = slave_done[1];
            end
            2'd2: begin
               slave_valid = {valid_sel, 2'b00};
               rdy_sel     = slave_ready[2];
               done_sel    = slave_done[2];
            end
            default: sel_err = 1'b1;
         endcase
      end
      m1_ready = m1_grant & rdy_sel;
      m1_done  = m1_grant & done_sel;
      m2_ready = m2_grant & rdy_sel;
      m2_done  = m2_grant & done_sel;
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter with TIMEOUT_CYC=16.
`default_nettype none

module tb_bus_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       m1_req, m2_req, m1_grant, m2_grant;
   logic       m1_valid, m1_addr, m1_data, m1_burst, m1_rd, m1_wr;
   logic       m2_valid, m2_addr, m2_data, m2_burst, m2_rd, m2_wr;
   logic [1:0] m1_sel, m2_sel;
   logic       bus_addr, bus_data, bus_burst, bus_rd, bus_wr;
   logic [2:0] slave_valid, slave_ready, slave_done;
   logic       m1_ready, m1_done, m2_ready, m2_done, timeout, sel_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bus_arbiter #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .reset(reset),
      .m1_req(m1_req), .m2_req(m2_req), .m1_grant(m1_grant), .m2_grant(m2_grant),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_data(m1_data), .m1_burst(m1_burst),
      .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_sel(m1_sel),
      .m2_valid(m2_valid), .m2_addr(m2_addr), .m2_data(m2_data), .m2_burst(m2_burst),
      .m2_rd(m2_rd), .m2_wr(m2_wr), .m2_sel(m2_sel),
      .bus_addr(bus_addr), .bus_data(bus_data), .bus_burst(bus_burst),
      .bus_rd(bus_rd), .bus_wr(bus_wr),
      .slave_valid(slave_valid), .slave_ready(slave_ready), .slave_done(slave_done),
      .m1_ready(m1_ready), .m1_done(m1_done), .m2_ready(m2_ready), .m2_done(m2_done),
      .timeout(timeout), .sel_err(sel_err)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b0;
      {m1_req, m2_req, m1_valid, m1_addr, m1_data, m1_burst, m1_rd, m1_wr} = '0;
      {m2_valid, m2_addr, m2_data, m2_burst, m2_rd, m2_wr} = '0;
      m1_sel = 2'd0; m2_sel = 2'd0;
      slave_ready = 3'b000; slave_done = 3'b000;
      #1;
      chk("rst_grants", {6'd0, m1_grant, m2_grant}, 8'h00);
      chk("rst_timeout", {7'd0, timeout}, 8'h00);
      chk("rst_svalid", {5'd0, slave_valid}, 8'h00);
      tick(); tick();
      reset = 1'b1;

      // Simultaneous request after reset: M1 holds priority.
      m1_req = 1'b1; m2_req = 1'b1;
      #1 chk("t2_pre_grant", {6'd0, m1_grant, m2_grant}, 8'h00);
      tick();
      #1 chk("t2_m1_first", {6'd0, m1_grant, m2_grant}, 8'h02);
      m1_req = 1'b0;
      tick();
      #1 chk("t2_turn", {6'd0, m1_grant, m2_grant}, 8'h00);
      tick();
      #1 chk("t2_idle", {6'd0, m1_grant, m2_grant}, 8'h00);
      tick();
      #1 chk("t2_m2_granted", {6'd0, m1_grant, m2_grant}, 8'h01);
      m2_req = 1'b0;
      tick(); tick();

      // Lone M1 request to slave 1.
      m1_req = 1'b1; m1_sel = 2'd1; m1_valid = 1'b1; m1_addr = 1'b1; m1_wr = 1'b1;
      slave_ready = 3'b010;
      tick();
      #1 chk("t1_grant", {6'd0, m1_grant, m2_grant}, 8'h02);
      chk("t1_svalid", {5'd0, slave_valid}, 8'h02);
      chk("t1_bus", {3'd0, bus_addr, bus_data, bus_burst, bus_rd, bus_wr}, 8'h11);
      chk("t1_ready", {6'd0, m1_ready, m2_ready}, 8'h02);
      m1_valid = 1'b0;
      #1 chk("t1_svalid_lo", {5'd0, slave_valid}, 8'h00);
      m1_req = 1'b0;
      tick();
      #1 chk("t1_release", {6'd0, m1_grant, m2_grant}, 8'h00);
      tick();
      m1_addr = 1'b0; m1_wr = 1'b0;

      // Invalid slave select; M1 is a lone requester even though M2 holds priority.
      m1_req = 1'b1; m1_sel = 2'd3; m1_valid = 1'b1; slave_ready = 3'b111;
      tick();
      #1 chk("t5_grant", {6'd0, m1_grant, m2_grant}, 8'h02);
      chk("t5_sel_err", {7'd0, sel_err}, 8'h01);
      chk("t5_svalid", {5'd0, slave_valid}, 8'h00);
      chk("t5_ready", {7'd0, m1_ready}, 8'h00);
      m1_sel = 2'd0;
      #1 chk("t5_svalid_s0", {5'd0, slave_valid}, 8'h01);
      chk("t5_sel_err_lo", {7'd0, sel_err}, 8'h00);
      m1_req = 1'b0; m1_valid = 1'b0;
      tick(); tick();

      // Watchdog: M2 holds request; M1 joins and must win after the revoke.
      m2_req = 1'b1;
      tick();
      for (int i = 1; i <= 16; i++) begin
         if (i == 5) m1_req = 1'b1;
         #1 chk($sformatf("t4_m2_hold%0d", i), {6'd0, m1_grant, m2_grant}, 8'h01);
         chk($sformatf("t4_no_to%0d", i), {7'd0, timeout}, 8'h00);
         if (i < 16) tick();
      end
      tick();
      #1 chk("t4_revoke", {6'd0, m1_grant, m2_grant}, 8'h00);
      chk("t4_timeout", {7'd0, timeout}, 8'h01);
      tick();
      #1 chk("t4_idle", {6'd0, m1_grant, m2_grant}, 8'h00);
      chk("t4_timeout_lo", {7'd0, timeout}, 8'h00);
      tick();
      #1 chk("t4_m1_wins", {6'd0, m1_grant, m2_grant}, 8'h02);

      // Both held: M1 times out, 2-cycle gap, then M2.
      for (int i = 2; i <= 16; i++) begin
         tick();
         #1 chk($sformatf("t3_m1_hold%0d", i), {6'd0, m1_grant, m2_grant}, 8'h02);
      end
      tick();
      #1 chk("t3_turn", {6'd0, m1_grant, m2_grant, timeout}, 8'h01);
      tick();
      #1 chk("t3_idle", {6'd0, m1_grant, m2_grant}, 8'h00);
      tick();
      #1 chk("t3_m2", {6'd0, m1_grant, m2_grant}, 8'h01);

      // Mux of M2 onto slave 2.
      m2_sel = 2'd2; m2_valid = 1'b1; m2_data = 1'b1; m2_burst = 1'b1; m2_rd = 1'b1;
      slave_done = 3'b100;
      #1 chk("m2_svalid", {5'd0, slave_valid}, 8'h04);
      chk("m2_bus", {3'd0, bus_addr, bus_data, bus_burst, bus_rd, bus_wr}, 8'h0E);
      chk("m2_done", {6'd0, m1_done, m2_done}, 8'h01);
      tick();

      // Reset mid-burst during M2's grant; afterwards M1 priority is restored.
      reset = 1'b0;
      #1 chk("t6_grants", {6'd0, m1_grant, m2_grant}, 8'h00);
      chk("t6_svalid", {5'd0, slave_valid}, 8'h00);
      chk("t6_bus", {3'd0, bus_addr, bus_data, bus_burst, bus_rd, bus_wr}, 8'h00);
      tick();
      reset = 1'b1;
      #1 chk("t6_idle", {6'd0, m1_grant, m2_grant}, 8'h00);
      tick();
      #1 chk("t6_m1_prio", {6'd0, m1_grant, m2_grant}, 8'h02);
      m1_req = 1'b0; m2_req = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
